// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: steps the fetch PC through a combinational instruction
// memory, buffers {pc, instr} pairs in a small FIFO and hands them to decode via valid/ready.
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic              pop;
    logic              push;
    logic              not_full;

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign busy      = (state == RUN);
    assign not_full  = (count < CNT_W'(DEPTH));

    // Head entry is presented directly; forced to zero while the FIFO is empty.
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

    always_comb begin
        pop  = out_valid & out_ready;
        push = (state == RUN) & en & ~redirect_valid & (not_full | pop);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en)  next_state = RUN;
            RUN:     if (!en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            // A redirect flushes everything buffered; a concurrent pop is dropped.
            state    <= next_state;
            fetch_pc <= redirect_pc;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= next_state;
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with a combinational memory model
// returning 32'hA000_0000 | address.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb imem_rdata = 32'hA000_0000 | imem_addr;

    typedef struct {
        logic        rst;
        logic        en;
        logic        rv;
        logic [31:0] rpc;
        logic        ready;
        logic        chk;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        busy;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(logic r, logic e, logic rv, logic [31:0] rpc, logic rdy,
                                logic chk, logic v, logic [31:0] pc, logic [31:0] ins,
                                logic [31:0] addr, logic b);
        vec_t t;
        t.rst = r; t.en = e; t.rv = rv; t.rpc = rpc; t.ready = rdy;
        t.chk = chk; t.valid = v; t.pc = pc; t.instr = ins; t.addr = addr; t.busy = b;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        rst = r; en = e; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [31:0] pc,
                               input logic [31:0] ins, input logic [31:0] addr, input logic b);
        cmp({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
        cmp({tag, ".out_pc"},    out_pc,    pc);
        cmp({tag, ".out_instr"}, out_instr, ins);
        cmp({tag, ".imem_addr"}, imem_addr, addr);
        cmp({tag, ".busy"},      {31'b0, busy}, {31'b0, b});
    endtask

    // One cycle: drive inputs just after the rising edge, sample on the falling edge.
    task automatic step(input string tag, input vec_t t);
        applyStimulus(t.rst, t.en, t.rv, t.rpc, t.ready);
        @(negedge clk);
        if (t.chk) checkOutput(tag, t.valid, t.pc, t.instr, t.addr, t.busy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset, then stream with ready high.
        vecs[0]  = mk(1,0,0,0,0, 0, 0,0,0,0,0);
        vecs[1]  = mk(0,0,0,0,1, 1, 0,0,0,0,0);
        vecs[2]  = mk(0,1,0,0,1, 1, 0,0,0,0,0);
        vecs[3]  = mk(0,1,0,0,1, 1, 0,0,0,0,1);
        vecs[4]  = mk(0,1,0,0,1, 1, 1,32'h0,32'hA000_0000,32'h1,1);
        vecs[5]  = mk(0,1,0,0,1, 1, 1,32'h1,32'hA000_0001,32'h2,1);
        vecs[6]  = mk(0,1,0,0,1, 1, 1,32'h2,32'hA000_0002,32'h3,1);
        vecs[7]  = mk(0,1,0,0,1, 1, 1,32'h3,32'hA000_0003,32'h4,1);
        vecs[8]  = mk(0,0,0,0,1, 1, 1,32'h4,32'hA000_0004,32'h5,1);
        vecs[9]  = mk(0,0,0,0,1, 1, 0,0,0,32'h5,0);
        // Reset, then backpressure for five cycles after the stream starts.
        vecs[10] = mk(1,0,0,0,0, 0, 0,0,0,0,0);
        vecs[11] = mk(0,1,0,0,0, 1, 0,0,0,0,0);
        vecs[12] = mk(0,1,0,0,0, 1, 0,0,0,0,1);
        vecs[13] = mk(0,1,0,0,0, 1, 1,32'h0,32'hA000_0000,32'h1,1);
        vecs[14] = mk(0,1,0,0,0, 1, 1,32'h0,32'hA000_0000,32'h2,1);
        vecs[15] = mk(0,1,0,0,0, 1, 1,32'h0,32'hA000_0000,32'h2,1);
        vecs[16] = mk(0,1,0,0,0, 1, 1,32'h0,32'hA000_0000,32'h2,1);
        // Full FIFO drained with ready high: push and pop together every cycle.
        vecs[17] = mk(0,1,0,0,1, 1, 1,32'h0,32'hA000_0000,32'h2,1);
        vecs[18] = mk(0,1,0,0,1, 1, 1,32'h1,32'hA000_0001,32'h3,1);
        vecs[19] = mk(0,1,0,0,1, 1, 1,32'h2,32'hA000_0002,32'h4,1);
        // Redirect to 0x40 while pc 3 is at the head.
        vecs[20] = mk(0,1,1,32'h40,1, 1, 1,32'h3,32'hA000_0003,32'h5,1);
        vecs[21] = mk(0,1,0,0,1, 1, 0,0,0,32'h40,1);
        vecs[22] = mk(0,1,0,0,1, 1, 1,32'h40,32'hA000_0040,32'h41,1);
        vecs[23] = mk(0,1,0,0,1, 1, 1,32'h41,32'hA000_0041,32'h42,1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 24; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Wrap-around through 0xFFFFFFFF.
        step("wrap0", mk(0,1,1,32'hFFFF_FFFF,1, 1, 1,32'h42,32'hA000_0042,32'h43,1));
        step("wrap1", mk(0,1,0,0,1, 1, 0,0,0,32'hFFFF_FFFF,1));
        step("wrap2", mk(0,1,0,0,1, 1, 1,32'hFFFF_FFFF,32'hFFFF_FFFF,32'h0,1));
        step("wrap3", mk(0,1,0,0,1, 1, 1,32'h0,32'hA000_0000,32'h1,1));
        step("wrap4", mk(0,1,0,0,1, 1, 1,32'h1,32'hA000_0001,32'h2,1));

        // Disable mid-stream: buffered entry still drains, then resume at the held PC.
        step("dis0", mk(0,0,0,0,0, 1, 1,32'h2,32'hA000_0002,32'h3,1));
        step("dis1", mk(0,0,0,0,0, 1, 1,32'h2,32'hA000_0002,32'h3,0));
        step("dis2", mk(0,0,0,0,1, 1, 1,32'h2,32'hA000_0002,32'h3,0));
        step("dis3", mk(0,1,0,0,1, 1, 0,0,0,32'h3,0));
        step("dis4", mk(0,1,0,0,1, 1, 0,0,0,32'h3,1));
        step("dis5", mk(0,1,0,0,1, 1, 1,32'h3,32'hA000_0003,32'h4,1));

        // Fill the FIFO, then reset with it full.
        step("rstf0", mk(0,1,0,0,0, 1, 1,32'h4,32'hA000_0004,32'h5,1));
        step("rstf1", mk(0,1,0,0,0, 1, 1,32'h4,32'hA000_0004,32'h6,1));
        step("rstf2", mk(1,1,0,0,0, 1, 1,32'h4,32'hA000_0004,32'h6,1));
        step("rstf3", mk(0,0,0,0,0, 1, 0,0,0,32'h0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch controller that sequences the word-addressed, combinational InstructionMemory (address in, instruction out, same cycle). It owns the fetch PC, drives the memory address, and buffers fetched {pc, instruction} pairs in a small FIFO. The FIFO feeds the decode stage through a valid/ready handshake. The block accepts branch/jump redirects that flush in-flight fetches. It sits between InstructionMemory and the core's decode stage.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
RESET_PC, 0, fetch PC loaded on reset
PC_STEP, 1, PC increment per fetch (memory is word-addressed)
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  fetch enable; IDLE->RUN when high, RUN->IDLE when low
imem_addr  out  ADDR_W  address to InstructionMemory, equals fetch_pc
imem_rdata  in  DATA_W  instruction from InstructionMemory (combinational from imem_addr)
redirect_valid  in  1  load new PC and flush buffered fetches
redirect_pc  in  ADDR_W  redirect target
out_valid  out  1  head FIFO entry valid
out_ready  in  1  decode accepts head entry
out_instr  out  DATA_W  head instruction
out_pc  out  ADDR_W  PC of head instruction
busy  out  1  high in RUN state

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-operation): state=IDLE, fetch_pc=RESET_PC, FIFO count=0, rd/wr pointers=0. After reset: out_valid=0, busy=0, imem_addr=RESET_PC. out_instr and out_pc are 0 while the FIFO is empty.
- imem_addr = fetch_pc combinationally, in every state.
- FSM, IDLE:
  - No enqueue.
  - en=1 -> RUN next cycle.
  - FIFO contents remain drainable.
- FSM, RUN:
  - push = en & ~redirect_valid & (count<DEPTH | pop).
  - On push: write {fetch_pc, imem_rdata} at the tail; fetch_pc <= fetch_pc+PC_STEP.
  - en=0 -> IDLE next cycle, with no push that cycle.
  - busy=1.
- pop = out_valid & out_ready. On pop, the head advances. out_valid = (count!=0). out_instr and out_pc come directly from the head entry, with no extra register stage.
- Full FIFO with pop in the same cycle: push and pop both occur, and count is unchanged. Full without pop: no push, and fetch_pc holds.
- Empty FIFO with push: the entry becomes visible next cycle. There is no bypass; minimum latency from address to out_valid is 1 cycle.
- Redirect (highest priority, any state):
  - FIFO count<=0 and pointers reset.
  - fetch_pc<=redirect_pc.
  - No push that cycle; any pop that cycle is discarded (it has no effect).
  - State is unchanged.
  - The next cycle has out_valid=0. In RUN, the first redirected instruction is enqueued that next cycle and is visible the cycle after that.
- Redirect and en=0 in the same RUN cycle: both apply (PC loaded, FIFO flushed, state->IDLE).
- Priority order: rst > redirect_valid > en/push/pop.
- fetch_pc wraps modulo 2^ADDR_W, with no error flag.
- Throughput: one instruction per cycle when out_ready is held high.
- Outputs hold stable while out_valid=1 and out_ready=0 (the standard valid/ready hold rule).
- Count is ADDR-independent and uses clog2(DEPTH)+1 bits.

Test Plan:
Common memory model: imem_rdata = 32'hA000_0000 | imem_addr.

- Reset then stream: rst 1 cycle, en=1, out_ready=1.
  - Expect out_valid first high 2 cycles after en rises.
  - Expect out_pc = 0,1,2,3 with out_instr = A0000000..A0000003 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles after stream start.
  - Expect count saturates at 2 and imem_addr holds at 2.
  - out_pc=0 / out_instr=A0000000 stay stable.
  - After ready=1, expect pc 0,1,2 with no gaps or duplicates.
- Redirect: while streaming at pc 3, redirect_valid=1, redirect_pc=32'h40 for 1 cycle.
  - Expect out_valid=0 the next cycle.
  - Then out_pc=40,41 with instr A0000040, A0000041; pc 4 is never delivered.
- Simultaneous full push/pop: FIFO full, then out_ready=1 continuously.
  - Expect one pop and one push per cycle and count stays 2.
- Wrap-around: redirect_pc=32'hFFFF_FFFF.
  - Expect out_pc sequence FFFFFFFF, 00000000, 00000001.
- Disable and reset mid-operation:
  - en=0 mid-stream: busy=0 next cycle and buffered entries still drain; en=1 resumes at the held fetch_pc.
  - rst asserted with FIFO full: out_valid=0, imem_addr=0 after the edge.
